// File: rtl/ldpc_iter_ctrl_if.sv
// ldpc_iter_ctrl_if: control/status bundle between the decoder
// wrapper (master) and the iteration sequencer (slave).
interface ldpc_iter_ctrl_if #(
   parameter int ITER_W = 5,
   parameter int CNT_W  = 8
);
   logic              start;
   logic              abort;
   logic [CNT_W-1:0]  cfg_init_cnt;
   logic [ITER_W-1:0] cfg_max_iter;
   logic              early_term_en;
   logic              syndrome_ok;
   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  init_cnt;
   logic [ITER_W-1:0] iter;
   logic              busy;
   logic              done;
   logic              converged;
   logic              aborted;

   modport master (
      output start, abort, cfg_init_cnt, cfg_max_iter,
      output early_term_en, syndrome_ok,
      input  cnt, init_cnt, iter, busy, done, converged, aborted
   );

   modport slave (
      input  start, abort, cfg_init_cnt, cfg_max_iter,
      input  early_term_en, syndrome_ok,
      output cnt, init_cnt, iter, busy, done, converged, aborted
   );
endinterface

// File: rtl/ldpc_iter_ctrl.sv
// ldpc_iter_ctrl: layered LDPC iteration sequencer driving the shared
// cnt/init_cnt phase buses, with early termination and abort.
module ldpc_iter_ctrl #(
   parameter int ITER_W = 5,
   parameter int CNT_W  = 8
) (
   input  logic            clk,
   input  logic            rst,
   ldpc_iter_ctrl_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_ITER,
      S_CHECK,
      S_DONE
   } state_t;

   localparam logic [CNT_W-1:0]  C_LO   = CNT_W'(3);
   localparam logic [CNT_W-1:0]  C_HI   = CNT_W'(253);
   localparam logic [CNT_W-1:0]  C_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0]  C_TWO  = CNT_W'(2);
   localparam logic [ITER_W-1:0] I_ONE  = ITER_W'(1);

   state_t            r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [CNT_W-1:0]  r_init_cnt;
   logic [ITER_W-1:0] r_iter;
   logic [ITER_W-1:0] r_max_iter;
   logic              r_busy;
   logic              r_done;
   logic              r_conv;
   logic              r_aborted;

   logic [CNT_W-1:0]  w_init_clamp;
   logic [ITER_W-1:0] w_max_load;
   logic [ITER_W-1:0] w_iter_inc;
   logic [ITER_W-1:0] w_iter_sat;
   logic [CNT_W-1:0]  w_cnt_last;
   logic              w_active;
   logic              w_start;
   logic              w_kill;
   logic              w_stop;

   // Step below 3 would collide with the load/first-update phases;
   // above 253 the V2C phase (init+1) would not fit before wrap.
   assign w_init_clamp = (bus.cfg_init_cnt < C_LO) ? C_LO :
                         (bus.cfg_init_cnt > C_HI) ? C_HI :
                         bus.cfg_init_cnt;
   assign w_max_load   = (bus.cfg_max_iter == '0) ? I_ONE :
                         bus.cfg_max_iter;

   assign w_iter_inc = r_iter + I_ONE;
   assign w_iter_sat = (r_iter >= r_max_iter) ? r_max_iter : w_iter_inc;
   assign w_cnt_last = r_init_cnt + C_ONE;

   assign w_active = (r_state == S_LOAD) ||
                     (r_state == S_ITER) ||
                     (r_state == S_CHECK);
   assign w_start  = bus.start & ~bus.abort;
   assign w_kill   = bus.abort & w_active;
   assign w_stop   = (bus.early_term_en & bus.syndrome_ok) |
                     (w_iter_inc == r_max_iter);

   // Sequencer FSM with all bus outputs held in registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_init_cnt <= '1;
         r_iter     <= '0;
         r_max_iter <= I_ONE;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_conv     <= 1'b0;
         r_aborted  <= 1'b0;
      end else begin
         r_done    <= 1'b0;
         r_aborted <= 1'b0;
         if (w_kill) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_aborted <= 1'b1;
         end else begin
            unique case (r_state)
               S_IDLE: begin
                  r_cnt <= '0;
                  if (w_start) begin
                     r_init_cnt <= w_init_clamp;
                     r_max_iter <= w_max_load;
                     r_iter     <= '0;
                     r_conv     <= 1'b0;
                     r_cnt      <= C_ONE;
                     r_busy     <= 1'b1;
                     r_state    <= S_LOAD;
                  end
               end
               S_LOAD: begin
                  r_cnt   <= C_TWO;
                  r_state <= S_ITER;
               end
               S_ITER: begin
                  if (r_cnt == w_cnt_last) begin
                     r_cnt   <= '0;
                     r_state <= S_CHECK;
                  end else begin
                     r_cnt <= r_cnt + C_ONE;
                  end
               end
               S_CHECK: begin
                  r_iter <= w_iter_sat;
                  if (w_stop) begin
                     r_conv  <= bus.syndrome_ok;
                     r_done  <= 1'b1;
                     r_busy  <= 1'b0;
                     r_cnt   <= '0;
                     r_state <= S_DONE;
                  end else begin
                     // Skip the L-load phase on later iterations.
                     r_cnt   <= C_TWO;
                     r_state <= S_ITER;
                  end
               end
               S_DONE: begin
                  r_cnt   <= '0;
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end
               default: begin
                  r_cnt   <= '0;
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end
            endcase
         end
      end
   end

   assign bus.cnt       = r_cnt;
   assign bus.init_cnt  = r_init_cnt;
   assign bus.iter      = r_iter;
   assign bus.busy      = r_busy;
   assign bus.done      = r_done;
   assign bus.converged = r_conv;
   assign bus.aborted   = r_aborted;

endmodule

// File: tb/tb_ldpc_iter_ctrl.sv
// tb_ldpc_iter_ctrl: table vectors, hand sequences and randomized
// decodes checked cycle by cycle against a phase-list model.
module tb_ldpc_iter_ctrl;

   logic clk;
   logic rst;

   ldpc_iter_ctrl_if bus ();

   ldpc_iter_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int          ci;
      int          mi;
      bit          et;
      logic [31:0] pat;
      int          ab;
      int          e_lat;
      int          e_iter;
      bit          e_conv;
      bit          e_ab;
   } vec_t;

   vec_t tbl[12];

   // model output: expected per-cycle trace after the start edge
   logic [7:0] cnt_q[$];
   int         it_q[$];
   bit         syn_q[$];
   int         m_term;
   int         m_ic;
   int         m_iter;
   bit         m_conv;
   bit         m_ab;

   function automatic void chk(string nm, logic [63:0] act,
                               logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
      end
   endfunction

   function automatic logic [24:0] pk(logic [7:0] c, logic [7:0] ic,
                                      logic [4:0] it, logic b,
                                      logic d, logic cv, logic ab);
      return {c, ic, it, b, d, cv, ab};
   endfunction

   function automatic logic [24:0] act_vec();
      return {bus.cnt, bus.init_cnt, bus.iter, bus.busy,
              bus.done, bus.converged, bus.aborted};
   endfunction

   // Decode as a list of phases: load, then per iteration
   // phases 2..init+1 and one check slot, until stop rule fires.
   task automatic model_build(input int ci, input int mi, input bit et,
                              input logic [31:0] pat, input int ab);
      int k;
      bit fin;
      cnt_q.delete();
      it_q.delete();
      syn_q.delete();
      m_ic = (ci < 3) ? 3 : (ci > 253) ? 253 : ci;
      mi   = (mi == 0) ? 1 : mi;
      cnt_q.push_back(8'd1);
      it_q.push_back(0);
      syn_q.push_back(1'b0);
      k   = 0;
      fin = 1'b0;
      while (!fin) begin
         for (int c = 2; c <= m_ic + 1; c++) begin
            cnt_q.push_back(8'(c));
            it_q.push_back(k);
            syn_q.push_back(1'b0);
         end
         cnt_q.push_back(8'd0);
         it_q.push_back(k);
         syn_q.push_back(pat[k]);
         k++;
         if ((et && pat[k-1]) || k == mi) fin = 1'b1;
      end
      m_term = cnt_q.size();
      if (ab >= 0 && ab < m_term) begin
         m_term = ab + 1;
         m_iter = it_q[ab];
         m_conv = 1'b0;
         m_ab   = 1'b1;
      end else begin
         m_iter = k;
         m_conv = pat[k-1];
         m_ab   = 1'b0;
      end
   endtask

   task automatic run_decode(input int ci, input int mi, input bit et,
                             input logic [31:0] pat, input int ab,
                             input bit noise, output int lat,
                             output int it, output bit cv,
                             output bit abo);
      logic [24:0] ev;
      model_build(ci, mi, et, pat, ab);
      @(negedge clk);
      bus.cfg_init_cnt  = 8'(ci);
      bus.cfg_max_iter  = 5'(mi);
      bus.early_term_en = et;
      bus.syndrome_ok   = 1'b0;
      bus.abort         = 1'b0;
      bus.start         = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      lat = -1;
      abo = 1'b0;
      for (int idx = 0; idx <= m_term; idx++) begin
         @(negedge clk);
         if (idx < m_term)
            ev = pk(cnt_q[idx], 8'(m_ic), 5'(it_q[idx]),
                    1'b1, 1'b0, 1'b0, 1'b0);
         else
            ev = pk(8'd0, 8'(m_ic), 5'(m_iter),
                    1'b0, !m_ab, m_conv, m_ab);
         chk($sformatf("cyc%0d", idx), 64'(act_vec()), 64'(ev));
         if (lat < 0 && (bus.done || bus.aborted)) begin
            lat = idx;
            abo = bus.aborted;
         end
         if (idx < m_term) begin
            bus.syndrome_ok = syn_q[idx];
            bus.abort       = (idx == ab);
            if (noise) begin
               bus.start        = ($urandom_range(0, 3) == 0);
               bus.cfg_init_cnt = 8'($urandom);
               bus.cfg_max_iter = 5'($urandom);
            end
         end else begin
            bus.start       = 1'b0;
            bus.abort       = 1'b0;
            bus.syndrome_ok = 1'b0;
         end
      end
      @(negedge clk);
      chk("hold", 64'(act_vec()),
          64'(pk(8'd0, 8'(m_ic), 5'(m_iter), 1'b0, 1'b0, m_conv, 1'b0)));
      it = int'(bus.iter);
      cv = bus.converged;
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1);
   end

   initial begin
      int lat, it;
      bit cv, abo;
      int ci, mi, ab;
      bit et;
      logic [31:0] pat;

      tbl[0]  = '{5,   2, 0, 32'h0,        -1, 13,  2,  0, 0};
      tbl[1]  = '{5,   8, 1, 32'h1,        -1, 7,   1,  1, 0};
      tbl[2]  = '{5,   0, 0, 32'h0,        -1, 7,   1,  0, 0};
      tbl[3]  = '{1,   1, 0, 32'h0,        -1, 5,   1,  0, 0};
      tbl[4]  = '{5,   3, 0, 32'h0,         9, 10,  1,  0, 1};
      tbl[5]  = '{255, 1, 0, 32'h0,        -1, 255, 1,  0, 0};
      tbl[6]  = '{4,   5, 1, 32'h4,        -1, 16,  3,  1, 0};
      tbl[7]  = '{3,   3, 0, 32'hFFFFFFFF, -1, 13,  3,  1, 0};
      tbl[8]  = '{3,  31, 0, 32'h0,        -1, 125, 31, 0, 0};
      tbl[9]  = '{6,   2, 0, 32'h0,         0, 1,   0,  0, 1};
      tbl[10] = '{3,   4, 0, 32'h0,         4, 5,   0,  0, 1};
      tbl[11] = '{0,   1, 1, 32'h1,        -1, 5,   1,  1, 0};

      rst               = 1'b1;
      bus.start         = 1'b0;
      bus.abort         = 1'b0;
      bus.cfg_init_cnt  = 8'd0;
      bus.cfg_max_iter  = 5'd0;
      bus.early_term_en = 1'b0;
      bus.syndrome_ok   = 1'b0;

      // asynchronous reset before any clock edge
      #2 rst = 1'b0;
      #1;
      chk("rst_async", 64'(act_vec()),
          64'(pk(8'd0, 8'hFF, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0)));
      @(negedge clk);
      rst = 1'b1;

      // start together with abort in idle, then abort alone
      bus.start = 1'b1;
      bus.abort = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("st_ab_idle", 64'(act_vec()),
             64'(pk(8'd0, 8'hFF, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0)));
      end
      bus.start = 1'b0;
      @(negedge clk);
      chk("ab_idle", 64'(act_vec()),
          64'(pk(8'd0, 8'hFF, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0)));
      bus.abort = 1'b0;

      foreach (tbl[i]) begin
         run_decode(tbl[i].ci, tbl[i].mi, tbl[i].et, tbl[i].pat,
                    tbl[i].ab, 1'b0, lat, it, cv, abo);
         chk($sformatf("t%0d_lat", i), 64'(lat), 64'(tbl[i].e_lat));
         chk($sformatf("t%0d_iter", i), 64'(it), 64'(tbl[i].e_iter));
         chk($sformatf("t%0d_conv", i), 64'(cv), 64'(tbl[i].e_conv));
         chk($sformatf("t%0d_abt", i), 64'(abo), 64'(tbl[i].e_ab));
      end

      for (int n = 0; n < 40; n++) begin
         ci  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 255)
                                           : $urandom_range(0, 12);
         mi  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 31)
                                           : $urandom_range(0, 5);
         if (ci > 40) mi = $urandom_range(0, 3);
         et  = 1'($urandom_range(0, 1));
         pat = $urandom & $urandom;
         model_build(ci, mi, et, pat, -1);
         ab  = ($urandom_range(0, 3) == 0)
             ? $urandom_range(0, m_term - 1) : -1;
         run_decode(ci, mi, et, pat, ab, 1'b1, lat, it, cv, abo);
         chk($sformatf("r%0d_lat", n), 64'(lat), 64'(m_term));
         chk($sformatf("r%0d_iter", n), 64'(it), 64'(m_iter));
      end

      // asynchronous reset in the middle of a decode
      @(negedge clk);
      bus.cfg_init_cnt = 8'd10;
      bus.cfg_max_iter = 5'd3;
      bus.start        = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      repeat (4) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      chk("rst_mid", 64'(act_vec()),
          64'(pk(8'd0, 8'hFF, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0)));
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_rel", 64'(act_vec()),
          64'(pk(8'd0, 8'hFF, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0)));

      run_decode(7, 2, 1, 32'h2, -1, 1'b0, lat, it, cv, abo);
      chk("post_lat", 64'(lat), 64'd17);
      chk("post_conv", 64'(cv), 64'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
